// File: rtl/accel_ctrl_pkg.sv
// accel_ctrl_pkg: shared encodings, states, micro-steps and control constants for the PE sequencer
package accel_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_DIST = 2'b00,
        OP_DOT  = 2'b01,
        OP_SUM  = 2'b10,
        OP_CMP  = 2'b11
    } op_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_STEP,
        ST_OUT,
        ST_DONE
    } state_t;
    typedef enum logic [2:0] {
        US_SUB,
        US_ADD,
        US_MUL,
        US_COM,
        US_BACK_IN,
        US_BACK_PAR,
        US_TREE
    } ustep_t;
    localparam logic [7:0] CU_SUB   = 8'h00;
    localparam logic [7:0] CU_ADD   = 8'hAA;
    localparam logic [7:0] CU_MUL   = 8'hFF;
    localparam logic [7:0] CU_COM   = 8'h55;
    localparam logic [7:0] GB_IN    = 8'hFF;
    localparam logic [7:0] GB_PAR   = 8'h55;
    localparam logic [7:0] ADDER_ON = 8'hAA;
    localparam logic [3:0] SAVE_ALL = 4'hF;
    localparam logic [1:0] SUM_DIST = 2'b10;
    localparam logic [1:0] SUM_ADD  = 2'b01;
    typedef struct packed {
        logic [7:0] sel_cu;
        logic [7:0] sel_cu_go_back;
        logic [7:0] sel_adder;
        logic [3:0] is_save_cu_out;
        logic [1:0] sum_row_pe;
        logic [1:0] sum_column_pe;
    } ctrl_word_t;
    // number of micro-steps each operation spends on one column
    function automatic logic [2:0] op_len(op_t op);
        return op == OP_DIST ? 3'd4 : 3'd2;
    endfunction
endpackage

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: decoder request inputs and PE-array / MLB control outputs of the sequencer
interface pe_seq_ctrl_if #(
    parameter int NUM_PE  = 32,
    parameter int NUM_COL = 8
);
    logic                       start;
    logic [1:0]                 op_sel;
    logic                       abort;
    logic                       read_en;
    logic [$clog2(NUM_PE)-1:0]  sel_pe;
    logic [$clog2(NUM_COL)-1:0] col_index;
    logic [7:0]                 sel_cu;
    logic [7:0]                 sel_cu_go_back;
    logic [7:0]                 sel_adder;
    logic [3:0]                 is_save_cu_out;
    logic [1:0]                 sum_row_pe;
    logic [1:0]                 sum_column_pe;
    logic                       sig;
    logic                       busy;
    logic                       done;
    modport master (
        output start, op_sel, abort,
        input  read_en, sel_pe, col_index, sel_cu, sel_cu_go_back, sel_adder,
        input  is_save_cu_out, sum_row_pe, sum_column_pe, sig, busy, done
    );
    modport slave (
        input  start, op_sel, abort,
        output read_en, sel_pe, col_index, sel_cu, sel_cu_go_back, sel_adder,
        output is_save_cu_out, sum_row_pe, sum_column_pe, sig, busy, done
    );
endinterface

// File: rtl/pe_step_decode.sv
// pe_step_decode: maps (operation, micro-step index) to the PE control word and a last-step flag
module pe_step_decode
    import accel_ctrl_pkg::*;
(
    input  op_t        op,
    input  logic [1:0] idx,
    output ctrl_word_t word,
    output logic       last
);
    ustep_t us;
    // pick the micro-step for this slot, then expand it to its control word
    always_comb begin
        case (op)
            OP_DIST: us = idx == 2'd0 ? US_SUB : idx == 2'd1 ? US_BACK_IN : idx == 2'd2 ? US_MUL : US_TREE;
            OP_DOT:  us = idx[0] ? US_TREE : US_MUL;
            OP_SUM:  us = idx[0] ? US_TREE : US_ADD;
            default: us = idx[0] ? US_BACK_PAR : US_COM;
        endcase
        word = '0;
        case (us)
            US_SUB:  word.sel_cu = CU_SUB;
            US_ADD:  word.sel_cu = CU_ADD;
            US_MUL:  word.sel_cu = CU_MUL;
            US_COM:  word.sel_cu = CU_COM;
            US_BACK_IN: begin
                word.is_save_cu_out = SAVE_ALL;
                word.sel_cu_go_back = GB_IN;
            end
            US_BACK_PAR: begin
                word.is_save_cu_out = SAVE_ALL;
                word.sel_cu_go_back = GB_PAR;
            end
            US_TREE: begin
                word.sel_adder     = ADDER_ON;
                word.sum_row_pe    = op == OP_SUM ? SUM_ADD : SUM_DIST;
                word.sum_column_pe = op == OP_SUM ? SUM_ADD : SUM_DIST;
            end
            default: word = '0;
        endcase
        last = idx == 2'(op_len(op) - 3'd1);
    end
endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: runs one vector operation: MLB load, latency wait, per-column micro-steps, capture, done
module pe_seq_ctrl
    import accel_ctrl_pkg::*;
#(
    parameter int NUM_PE  = 32,
    parameter int NUM_COL = 8,
    parameter int MLB_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    pe_seq_ctrl_if.slave bus
);
    localparam int PW = $clog2(NUM_PE);
    localparam int CW = $clog2(NUM_COL);
    localparam logic [PW-1:0] PE_LAST  = PW'(NUM_PE - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(NUM_COL - 1);
    localparam logic [2:0]    LAT_LAST = 3'(MLB_LAT - 1);
    state_t     state;
    op_t        op;
    logic [1:0] step;
    logic [1:0] step_nxt;
    logic       last_q;
    logic [2:0] wcnt;
    logic [PW-1:0] pe;
    logic [CW-1:0] col;
    logic       read_en;
    logic       sig;
    logic       busy;
    logic       done;
    logic       to_step;
    logic       nxt_last;
    ctrl_word_t word;
    ctrl_word_t nxt_w;
    // the decoder looks one step ahead so the control word lands in the register with its state
    assign step_nxt = (state == ST_STEP && !last_q) ? step + 2'd1 : 2'd0;
    assign to_step = !bus.abort && (
        (state == ST_LOAD && pe == PE_LAST && MLB_LAT == 0) ||
        (state == ST_WAIT && wcnt == LAT_LAST) ||
        (state == ST_STEP && !(last_q && col == COL_LAST)));
    pe_step_decode u_dec (
        .op   (op),
        .idx  (step_nxt),
        .word (nxt_w),
        .last (nxt_last)
    );
    // sequencer FSM with counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op      <= OP_DIST;
            step    <= 2'd0;
            last_q  <= 1'b0;
            wcnt    <= 3'd0;
            pe      <= '0;
            col     <= '0;
            read_en <= 1'b0;
            sig     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            word    <= '0;
        end else begin
            word   <= to_step ? nxt_w : '0;
            last_q <= to_step && nxt_last;
            step   <= to_step ? step_nxt : 2'd0;
            if (bus.abort && state != ST_IDLE) begin
                state   <= ST_IDLE;
                wcnt    <= 3'd0;
                pe      <= '0;
                col     <= '0;
                read_en <= 1'b0;
                sig     <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (bus.start) begin
                        op      <= op_t'(bus.op_sel);
                        state   <= ST_LOAD;
                        read_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                    ST_LOAD: if (pe == PE_LAST) begin
                        pe      <= '0;
                        read_en <= 1'b0;
                        state   <= MLB_LAT == 0 ? ST_STEP : ST_WAIT;
                    end else begin
                        pe <= pe + PW'(1);
                    end
                    ST_WAIT: if (wcnt == LAT_LAST) begin
                        wcnt  <= 3'd0;
                        state <= ST_STEP;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                    ST_STEP: if (last_q) begin
                        if (col == COL_LAST) begin
                            col   <= '0;
                            sig   <= 1'b1;
                            state <= ST_OUT;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    ST_OUT: begin
                        sig   <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                    ST_DONE: begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
    assign bus.read_en        = read_en;
    assign bus.sel_pe         = pe;
    assign bus.col_index      = col;
    assign bus.sel_cu         = word.sel_cu;
    assign bus.sel_cu_go_back = word.sel_cu_go_back;
    assign bus.sel_adder      = word.sel_adder;
    assign bus.is_save_cu_out = word.is_save_cu_out;
    assign bus.sum_row_pe     = word.sum_row_pe;
    assign bus.sum_column_pe  = word.sum_column_pe;
    assign bus.sig            = sig;
    assign bus.busy           = busy;
    assign bus.done           = done;
endmodule
